// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
// apb_slave_regfile : APB completer with a windowed, byte-strobed register file
// Revision 1.0
// ============================================================================
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM     = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    pclk_i,
  input  logic                    prstn_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic [2:0]              pport_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  input  logic [ADDR_WIDTH-1:0]   reg_addr_high_i,
  input  logic [ADDR_WIDTH-1:0]   reg_addr_low_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o
);

  localparam int         IDX_W     = $clog2(REG_NUM);
  localparam int         STRB_W    = DATA_WIDTH / 8;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  enter_done;
  logic                  pready_nxt;
  logic                  pslverr_nxt;
  logic [DATA_WIDTH-1:0] prdata_nxt;

  logic                  xfer_write;
  logic                  xfer_err;
  logic [IDX_W-1:0]      xfer_idx;
  logic [DATA_WIDTH-1:0] xfer_wdata;
  logic [STRB_W-1:0]     xfer_strb;

  logic [DATA_WIDTH-1:0] mem [REG_NUM];

  logic                  setup_phase;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  live_err;
  logic [IDX_W-1:0]      live_idx;
  logic                  cur_write;
  logic                  cur_err;
  logic [IDX_W-1:0]      cur_idx;
  logic                  commit;
  logic                  unused_ok;

  assign setup_phase = psel_i & ~penable_i;
  assign offset      = paddr_i - reg_addr_low_i;
  assign live_err    = (paddr_i < reg_addr_low_i) | (paddr_i > reg_addr_high_i) |
                       (paddr_i[1:0] != 2'b00);
  // Masking the word offset to the index width makes the window alias.
  assign live_idx    = offset[IDX_W+1:2];

  // With zero wait states DONE is entered straight from the setup cycle,
  // before the attributes are latched, so use the live decode there.
  assign cur_write = (state == IDLE) ? pwrite_i : xfer_write;
  assign cur_err   = (state == IDLE) ? live_err : xfer_err;
  assign cur_idx   = (state == IDLE) ? live_idx : xfer_idx;

  assign commit    = (state == DONE) & psel_i & xfer_write & ~xfer_err;

  assign unused_ok = &{1'b0, pport_i, offset};

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (setup_phase) begin
          cnt_nxt = WAIT_LOAD;
          if (WAIT_LOAD == 4'd0) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!psel_i) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (penable_i) begin
          if (cnt <= 4'd1) begin
            state_nxt  = DONE;
            cnt_nxt    = 4'd0;
            enter_done = 1'b1;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    pready_nxt  = enter_done;
    pslverr_nxt = enter_done & cur_err;
    prdata_nxt  = (enter_done & ~cur_write & ~cur_err) ? mem[cur_idx] : '0;
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      pready_o  <= 1'b0;
      pslverr_o <= 1'b0;
      prdata_o  <= '0;
    end else begin
      pready_o  <= pready_nxt;
      pslverr_o <= pslverr_nxt;
      prdata_o  <= prdata_nxt;
    end
  end

  // Window bounds are only consulted here, so later bound changes cannot
  // disturb a transfer already in flight.
  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      xfer_write <= 1'b0;
      xfer_err   <= 1'b0;
      xfer_idx   <= '0;
      xfer_wdata <= '0;
      xfer_strb  <= '0;
    end else if ((state == IDLE) && setup_phase) begin
      xfer_write <= pwrite_i;
      xfer_err   <= live_err;
      xfer_idx   <= live_idx;
      xfer_wdata <= pwdata_i;
      xfer_strb  <= pstrb_i;
    end
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      for (int r = 0; r < REG_NUM; r++) begin
        mem[r] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (xfer_strb[b]) begin
          mem[xfer_idx][b*8 +: 8] <= xfer_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// Directed bench for apb_slave_regfile: a 2-wait-state and a 0-wait-state
// instance share one APB bus and are selected by their own psel.
module tb_apb_slave_regfile;

  localparam logic [31:0] LOW  = 32'h5000_2000;
  localparam logic [31:0] HIGH = 32'h5000_FFFF;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pport = 3'b000;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic        psel_a = 1'b0;
  logic        psel_b = 1'b0;

  logic        rdy_a, err_a, rdy_b, err_b;
  logic [31:0] rd_a, rd_b;

  bit          sel_b = 1'b0;
  logic        cur_rdy, cur_err;
  logic [31:0] cur_rd;
  assign cur_rdy = sel_b ? rdy_b : rdy_a;
  assign cur_err = sel_b ? err_b : err_a;
  assign cur_rd  = sel_b ? rd_b  : rd_a;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(16), .WAIT_CYCLES(2)) dut_a (
    .pclk_i(clk), .prstn_i(rstn), .paddr_i(paddr), .pport_i(pport),
    .psel_i(psel_a), .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .reg_addr_high_i(HIGH), .reg_addr_low_i(LOW),
    .pready_o(rdy_a), .prdata_o(rd_a), .pslverr_o(err_a)
  );

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_NUM(16), .WAIT_CYCLES(0)) dut_b (
    .pclk_i(clk), .prstn_i(rstn), .paddr_i(paddr), .pport_i(pport),
    .psel_i(psel_b), .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .reg_addr_high_i(HIGH), .reg_addr_low_i(LOW),
    .pready_o(rdy_b), .prdata_o(rd_b), .pslverr_o(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                      input logic [3:0] sb, input logic [31:0] exp_rd, input bit exp_err,
                      input bit b2b, input string tag);
    exp_t e;
    bit   got;
    int   lat;
    exp_q.push_back('{rd: exp_rd, err: exp_err, lat: (sel_b ? 8'd1 : 8'd3)});
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wd;
    pstrb   = sb;
    penable = 1'b0;
    if (sel_b) psel_b = 1'b1;
    else       psel_a = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 16 && !got; k++) begin
      @(negedge clk);
      penable = 1'b1;
      if (cur_rdy) begin
        got = 1'b1;
        lat = k;
      end
    end
    vectors++;
    assert (got) else begin
      miscompares++;
      $error("FAIL %s timeout: observed=no pready expected=pready within 16 cycles", tag);
    end
    e = exp_q.pop_front();
    if (got) begin
      check({tag, " rdata"}, cur_rd, e.rd);
      check({tag, " pslverr"}, {31'd0, cur_err}, {31'd0, e.err});
      check({tag, " latency"}, 32'(lat), {24'd0, e.lat});
    end
    @(negedge clk);
    check({tag, " pready after done"}, {31'd0, cur_rdy}, 32'd0);
    penable = 1'b0;
    if (!b2b) begin
      psel_a = 1'b0;
      psel_b = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("reset pready_a", {31'd0, rdy_a}, 32'd0);
    check("reset prdata_a", rd_a, 32'd0);
    check("reset pslverr_a", {31'd0, err_a}, 32'd0);
    check("reset pready_b", {31'd0, rdy_b}, 32'd0);
    check("reset prdata_b", rd_b, 32'd0);
    check("reset pslverr_b", {31'd0, err_b}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    sel_b = 1'b0;
    xfer(32'h5000_2004, 1, 32'hDEAD_BEAF, 4'hF, 32'h0, 0, 0, "wr_full");
    xfer(32'h5000_2004, 0, 32'h0, 4'h0, 32'hDEAD_BEAF, 0, 0, "rd_full");
    xfer(32'h5000_2004, 1, 32'h1234_5678, 4'h3, 32'h0, 0, 0, "wr_strb_lo");
    xfer(32'h5000_2004, 0, 32'h0, 4'h0, 32'hDEAD_5678, 0, 0, "rd_strb_lo");
    xfer(32'h5000_2044, 0, 32'h0, 4'h0, 32'hDEAD_5678, 0, 0, "rd_alias1");
    xfer(32'h5000_2004, 1, 32'hA5A5_A5A5, 4'hC, 32'h0, 0, 0, "wr_strb_hi");
    xfer(32'h5000_2004, 0, 32'h0, 4'h0, 32'hA5A5_5678, 0, 0, "rd_strb_hi");
    xfer(32'h5000_203C, 1, 32'h0, 4'hF, 32'h0, 0, 0, "wr_zero");
    xfer(32'h5000_203C, 0, 32'h0, 4'h0, 32'h0, 0, 0, "rd_zero");
    xfer(32'hDEAD_BEAC, 1, 32'h1234_5678, 4'hF, 32'h0, 1, 0, "err_high_wr");
    xfer(32'h1234_5678, 0, 32'h0, 4'h0, 32'h0, 1, 0, "err_low_rd");
    xfer(32'h5000_2001, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, "err_misalign_wr");
    xfer(32'h5000_2000, 0, 32'h0, 4'h0, 32'h0, 0, 0, "rd_idx0");
    xfer(32'h5000_FFFC, 1, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 1, "a_b2b_wr");
    xfer(32'h5000_FFFC, 0, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 0, "a_b2b_rd");
    xfer(32'h5000_203C, 0, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 0, "rd_alias15");

    sel_b = 1'b1;
    xfer(32'h5000_FFFC, 1, 32'h0BAD_C0DE, 4'hF, 32'h0, 0, 1, "b_b2b_wr");
    xfer(32'h5000_FFFC, 0, 32'h0, 4'h0, 32'h0BAD_C0DE, 0, 0, "b_b2b_rd");
    sel_b = 1'b0;

    paddr = 32'h5000_2008; pwrite = 1'b1; pwdata = 32'h5555_5555; pstrb = 4'hF;
    penable = 1'b0; psel_a = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    rstn = 1'b0;
    #1;
    check("mid-reset pready", {31'd0, rdy_a}, 32'd0);
    check("mid-reset prdata", rd_a, 32'd0);
    check("mid-reset pslverr", {31'd0, err_a}, 32'd0);
    @(negedge clk);
    psel_a = 1'b0; penable = 1'b0; rstn = 1'b1;
    @(negedge clk);
    xfer(32'h5000_2008, 0, 32'h0, 4'h0, 32'h0, 0, 0, "rd_after_rst");
    xfer(32'h5000_2004, 0, 32'h0, 4'h0, 32'h0, 0, 0, "rd_cleared");

    xfer(32'h5000_2010, 1, 32'h1111_1111, 4'hF, 32'h0, 0, 0, "wr_pre_abort");
    paddr = 32'h5000_2010; pwrite = 1'b1; pwdata = 32'hAAAA_AAAA; pstrb = 4'hF;
    penable = 1'b0; psel_a = 1'b1;
    @(negedge clk);
    penable = 1'b1;
    seen = rdy_a;
    @(negedge clk);
    seen = seen | rdy_a;
    psel_a = 1'b0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | rdy_a;
    end
    check("abort pready", {31'd0, seen}, 32'd0);
    xfer(32'h5000_2010, 0, 32'h0, 4'h0, 32'h1111_1111, 0, 0, "rd_after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
